// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: data width, FSM state encoding and the
//            baud divisor helper, used by both uart_tx and uart_rx.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Clocks per bit-time; integer division truncates toward zero.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Single-clock byte FIFO for the UART transmitter. Push/pop are
//            qualified internally by full/empty; push and pop in the same
//            cycle both take effect and leave the count unchanged.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Buffered UART transmitter. Bytes enter a FIFO over valid/ready
//            and leave as back-to-back 8N1 frames, LSB first, on a registered
//            tx line. Define UART_TX_PARITY_EN for 8E1 framing (even parity
//            bit captured at pop, inserted between data and stop).
// Revision : 1.0
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [UART_DATA_W-1:0]      tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_tx;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_bit_end;
  logic [UART_DATA_W-1:0] w_pop_data;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  assign w_bit_end = (r_cnt == CNT_MAX);
  // Pop when idle with data waiting, or at the last stop-bit cycle so the
  // next start bit follows with no idle gap.
  assign w_pop     = !w_empty &&
                     ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  assign tx_ready  = !w_full;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign tx        = r_tx;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, latched as it leaves the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_pop_data;
  end
`endif

  // Frame sequencer: state, baud counter, shift register and the tx flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_tx  <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_pop_data;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_shift <= w_pop_data;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
